// File: rtl/fxu_pipe.sv
// fxu_pipe: pipelined fixed-point execution unit for the out-of-order core.
// Decoded ALU/move micro-ops enter through a valid/ready issue port. Each op's
// result is computed at entry and carried with its ROB tag through STAGES
// elastic stages. It leaves through a valid/ready writeback port.
// A flush squashes every in-flight op. Unsupported opcodes still retire, in
// order, with value 0 and the exception flag set.
// Optional feature: define FXU_SHIFT_EN to add shl (0010) / shr (0011).
// Without that macro, no shifter is built and both opcodes retire as
// unsupported.
module fxu_pipe #(
    parameter int DATA_W = 16,
    parameter int TAG_W  = 4,
    parameter int IMM_W  = 8,
    parameter int STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_opcode,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic [DATA_W-1:0] in_vt,
    input  logic [DATA_W-1:0] in_va,
    input  logic [DATA_W-1:0] in_vb,
    input  logic [IMM_W-1:0]  in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TAG_W-1:0]  out_tag,
    output logic [DATA_W-1:0] out_value,
    output logic              out_exc
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MOV  = 4'b0100;
    localparam logic [3:0] OP_MOVL = 4'b0101;
    localparam logic [3:0] OP_MOVH = 4'b0110;
`ifdef FXU_SHIFT_EN
    localparam logic [3:0] OP_SHL  = 4'b0010;
    localparam logic [3:0] OP_SHR  = 4'b0011;
    // Only the low log2(DATA_W) bits of vb select the shift distance.
    localparam int         SH_W    = $clog2(DATA_W);
`endif

    // The result is returned as {exc, value}. Unknown opcodes give value 0
    // with exc set.
    function automatic logic [DATA_W:0] execute(
        input logic [3:0]        op,
        input logic [DATA_W-1:0] vt,
        input logic [DATA_W-1:0] va,
        input logic [DATA_W-1:0] vb,
        input logic [IMM_W-1:0]  imm
    );
        logic [DATA_W-1:0] value;
        logic              exc;
        value = '0;
        exc   = 1'b0;
        case (op)
            OP_ADD:  value = va + vb;
            OP_SUB:  value = va - vb;
            OP_MOV:  value = va;
            OP_MOVL: value = {vt[DATA_W-1:IMM_W], imm};
            OP_MOVH: value = {imm, vt[DATA_W-IMM_W-1:0]};
`ifdef FXU_SHIFT_EN
            OP_SHL:  value = va << vb[SH_W-1:0];
            OP_SHR:  value = va >> vb[SH_W-1:0];
`endif
            default: exc = 1'b1;
        endcase
        return {exc, value};
    endfunction

    // Per-stage state; index STAGES-1 is the stage that drives the outputs.
    logic [STAGES-1:0] vld_p;
    logic [STAGES-1:0] exc_p;
    logic [TAG_W-1:0]  tag_p   [STAGES];
    logic [DATA_W-1:0] value_p [STAGES];

    // Movement control.
    logic [STAGES-1:0] room_p;
    logic [STAGES-1:0] adv_p;
    logic [STAGES-1:0] load_p;

    logic              entry_exc;
    logic [DATA_W-1:0] entry_value;
    logic              accept;

    assign {entry_exc, entry_value} = execute(in_opcode, in_vt, in_va, in_vb, in_imm);

    // A valid stage can move when some stage above it is empty or the output drains.
    // This form avoids a ripple through adv_p, so no combinational loop appears.
    always_comb begin
        room_p = '0;
        adv_p  = '0;
        load_p = '0;
        for (int k = 0; k < STAGES; k++) begin
            room_p[k] = out_ready;
            for (int j = k + 1; j < STAGES; j++) begin
                if (!vld_p[j]) room_p[k] = 1'b1;
            end
            adv_p[k]  = vld_p[k] & room_p[k];
            load_p[k] = ~vld_p[k] | room_p[k];
        end
    end

    assign in_ready = rst_n & ~flush & load_p[0];
    assign accept   = in_valid & in_ready;

    // Valid bits: cleared by reset or flush, otherwise follow the data movement.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p <= '0;
        end else if (flush) begin
            vld_p <= '0;
        end else begin
            if (load_p[0]) vld_p[0] <= accept;
            for (int k = 1; k < STAGES; k++) begin
                if (load_p[k]) vld_p[k] <= adv_p[k-1];
            end
        end
    end

    // Payload: reset to zero so the outputs read 0 after reset, then shift with the valid bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exc_p <= '0;
            for (int k = 0; k < STAGES; k++) begin
                tag_p[k]   <= '0;
                value_p[k] <= '0;
            end
        end else if (!flush) begin
            if (accept) begin
                tag_p[0]   <= in_tag;
                value_p[0] <= entry_value;
                exc_p[0]   <= entry_exc;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (adv_p[k-1]) begin
                    tag_p[k]   <= tag_p[k-1];
                    value_p[k] <= value_p[k-1];
                    exc_p[k]   <= exc_p[k-1];
                end
            end
        end
    end

    assign out_valid = vld_p[STAGES-1];
    assign out_tag   = tag_p[STAGES-1];
    assign out_value = value_p[STAGES-1];
    assign out_exc   = exc_p[STAGES-1];

endmodule
